// File: rtl/spi_master_param.sv
// Parameterised SPI master that moves one full-duplex DATA_W-bit word per start.
// It supports all four SPI modes, MSB- or LSB-first order, and an SCLK half-period of DIV clk cycles.
module spi_master_param #(
    parameter int DATA_W = 16,
    parameter int DIV    = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              lsb_first,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              ready,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_n,
    output logic              spi_str
);
    localparam int            EW        = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);
    localparam logic [7:0]    RELOAD    = 8'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_XFER   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_STROBE = 3'd4
    } state_t;

    state_t            state_r, state_s;
    logic [7:0]        cnt_r;
    logic [EW-1:0]     edge_r;
    logic [DATA_W-1:0] tx_r, rx_r;
    logic              cpol_r, cpha_r, lsb_r;
    logic              tick_s, accept_s, lead_s, last_s;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        if (lsb) return w[0];
        else     return w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        if (lsb) return {1'b0, w[DATA_W-1:1]};
        else     return {w[DATA_W-2:0], 1'b0};
    endfunction

    // Bits are assembled in transmit order: first sample ends up at the MSB, or at the LSB when lsb-first.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b, input logic lsb);
        if (lsb) return {b, w[DATA_W-1:1]};
        else     return {w[DATA_W-2:0], b};
    endfunction

    assign tick_s   = (state_r != ST_IDLE) && (cnt_r == 8'd0);
    assign accept_s = (state_r == ST_IDLE) && start;
    assign lead_s   = ~edge_r[0];
    assign last_s   = (edge_r == LAST_EDGE);

    // Half-period counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                cnt_r <= 8'd0;
        else if (accept_s || tick_s) cnt_r <= RELOAD;
        else if (cnt_r != 8'd0)      cnt_r <= cnt_r - 8'd1;
        else                         cnt_r <= cnt_r;
    end

    // SCLK edge counter within XFER
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            edge_r <= '0;
        else if (accept_s)                       edge_r <= '0;
        else if (state_r == ST_XFER && tick_s)   edge_r <= edge_r + EW'(1);
        else                                     edge_r <= edge_r;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (start)            state_s = ST_SETUP;  else state_s = ST_IDLE;
            ST_SETUP:  if (tick_s)           state_s = ST_XFER;   else state_s = ST_SETUP;
            ST_XFER:   if (tick_s && last_s) state_s = ST_HOLD;   else state_s = ST_XFER;
            ST_HOLD:   if (tick_s)           state_s = ST_STROBE; else state_s = ST_HOLD;
            ST_STROBE: if (tick_s)           state_s = ST_IDLE;   else state_s = ST_STROBE;
            default:                         state_s = ST_IDLE;
        endcase
    end

    // Registered SPI pins, shift registers and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= 1'b1;
            spi_str  <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            dout     <= '0;
            tx_r     <= '0;
            rx_r     <= '0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            lsb_r    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    spi_clk  <= mode[1];
                    spi_cs_n <= 1'b1;
                    spi_str  <= 1'b0;
                    if (start) begin
                        cpol_r   <= mode[1];
                        cpha_r   <= mode[0];
                        lsb_r    <= lsb_first;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        rx_r     <= '0;
                        // CPHA=0 needs the first bit on the wire before the first leading edge
                        if (!mode[0]) begin
                            spi_mosi <= first_bit(data, lsb_first);
                            tx_r     <= shift_out(data, lsb_first);
                        end else begin
                            tx_r     <= data;
                        end
                    end
                end
                ST_SETUP: begin
                    spi_cs_n <= 1'b0;
                end
                ST_XFER: begin
                    if (tick_s) begin
                        spi_clk <= ~spi_clk;
                        if (lead_s) begin
                            if (!cpha_r) begin
                                rx_r <= shift_in(rx_r, spi_miso, lsb_r);
                            end else begin
                                spi_mosi <= first_bit(tx_r, lsb_r);
                                tx_r     <= shift_out(tx_r, lsb_r);
                            end
                        end else begin
                            if (cpha_r) begin
                                rx_r <= shift_in(rx_r, spi_miso, lsb_r);
                            end else if (!last_s) begin
                                spi_mosi <= first_bit(tx_r, lsb_r);
                                tx_r     <= shift_out(tx_r, lsb_r);
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick_s) begin
                        spi_cs_n <= 1'b1;
                        spi_str  <= 1'b1;
                    end
                end
                ST_STROBE: begin
                    if (tick_s) begin
                        spi_str  <= 1'b0;
                        spi_mosi <= 1'b0;
                        spi_clk  <= cpol_r;
                        busy     <= 1'b0;
                        ready    <= 1'b1;
                        dout     <= rx_r;
                    end
                end
                default: begin
                    spi_cs_n <= 1'b1;
                    spi_str  <= 1'b0;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: a 16-bit DIV=12 instance and an 8-bit DIV=1 instance,
// exercised with loopback and a mode-aware slave model.
module tb_spi_master_param;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        start_a = 1'b0, lsb_a = 1'b0, loop_a = 1'b1;
    logic [15:0] data_a = 16'h0000;
    logic [1:0]  mode_a = 2'b00;
    logic [15:0] dout_a;
    logic        busy_a, ready_a, spi_clk_a, spi_mosi_a, spi_cs_n_a, spi_str_a, miso_a;

    logic        start_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic [7:0]  dout_b;
    logic        busy_b, ready_b, spi_clk_b, spi_mosi_b, spi_cs_n_b, spi_str_b;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q_a[$];
    logic [7:0]  q_b[$];
    logic [15:0] slave_word = 16'h3C5A;
    logic        cur_cpol = 1'b0, cur_cpha = 1'b0, b2b_chk = 1'b0;
    int          tog_a = 0, rises_a = 0, unstable_a = 0, str_cnt = 0, tog_b = 0;
    int          cyc = 0, t_start = 0, ready_cyc = 0, done_a = 0;
    logic [15:0] mosi_seen = 16'h0000;
    int          slave_k;
    logic        slave_bit;

    spi_master_param #(.DATA_W(16), .DIV(12)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .data(data_a), .mode(mode_a),
        .lsb_first(lsb_a), .dout(dout_a), .busy(busy_a), .ready(ready_a),
        .spi_clk(spi_clk_a), .spi_mosi(spi_mosi_a), .spi_miso(miso_a),
        .spi_cs_n(spi_cs_n_a), .spi_str(spi_str_a)
    );

    spi_master_param #(.DATA_W(8), .DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .data(data_b), .mode(2'b00),
        .lsb_first(1'b0), .dout(dout_b), .busy(busy_b), .ready(ready_b),
        .spi_clk(spi_clk_b), .spi_mosi(spi_mosi_b), .spi_miso(spi_mosi_b),
        .spi_cs_n(spi_cs_n_b), .spi_str(spi_str_b)
    );

    always #5 clk = ~clk;

    // Slave returns slave_word MSB-first, shifting on the edges its mode dictates
    always_comb begin
        slave_k   = cur_cpha ? ((tog_a == 0) ? 0 : (tog_a - 1) / 2) : tog_a / 2;
        slave_bit = 1'b0;
        if (slave_k < 16) slave_bit = slave_word[15 - slave_k];
        miso_a    = loop_a ? spi_mosi_a : slave_bit;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15 - i];
        return r;
    endfunction

    // SCLK edge watcher for instance A: edge counts, mosi seen at sampling edges
    initial begin
        logic prev_sclk, prev_mosi, prev_busy, samp;
        prev_sclk = 1'b0; prev_mosi = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_a && !prev_busy) begin
                rises_a = 0; unstable_a = 0; mosi_seen = 16'h0000;
            end
            if (spi_cs_n_a) begin
                tog_a = 0;
            end else if (spi_clk_a != prev_sclk) begin
                tog_a++;
                if (spi_clk_a) rises_a++;
                samp = cur_cpha ? (spi_clk_a == cur_cpol) : (spi_clk_a != cur_cpol);
                if (samp) begin
                    mosi_seen = {mosi_seen[14:0], spi_mosi_a};
                    if (spi_mosi_a != prev_mosi) unstable_a++;
                end
            end
            prev_sclk = spi_clk_a; prev_mosi = spi_mosi_a; prev_busy = busy_a;
        end
    end

    // SCLK edge counter for instance B
    initial begin
        logic prev_sclk, prev_busy;
        prev_sclk = 1'b0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_b && !prev_busy) tog_b = 0;
            else if (!spi_cs_n_b && spi_clk_b != prev_sclk) tog_b++;
            prev_sclk = spi_clk_b; prev_busy = busy_b;
        end
    end

    // Completion monitor for instance A: pops the scoreboard on every ready pulse
    initial begin
        logic busy_q, ready_q;
        logic [15:0] e;
        busy_q = 1'b0; ready_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (ready_q) check_val("ready_pulse", ready_a, 1'b0);
            if (busy_a && !busy_q) begin
                if (b2b_chk) check_val("idle_gap", cyc - ready_cyc, 1);
                t_start = cyc; str_cnt = 0;
            end
            if (spi_str_a) str_cnt++;
            if (ready_a) begin
                check_val("sb_depth", q_a.size() > 0, 1'b1);
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    check_val("dout", dout_a, e);
                end
                check_val("latency", cyc - t_start, 420);
                check_val("strobe_len", str_cnt, 12);
                check_val("done_pins", {spi_cs_n_a, spi_str_a, busy_a, spi_mosi_a}, 4'b1000);
                ready_cyc = cyc;
                done_a++;
            end
            busy_q = busy_a; ready_q = ready_a;
        end
    end

    task automatic wait_done_a(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a >= target) break;
        end
        check_val("done_timeout", done_a >= target, 1'b1);
    endtask

    task automatic do_xfer(input logic [15:0] d, input logic [1:0] m, input logic lsb,
                           input logic loop, input logic [15:0] exp);
        int n0;
        @(negedge clk);
        data_a = d; mode_a = m; lsb_a = lsb; loop_a = loop; cur_cpol = m[1]; cur_cpha = m[0];
        @(negedge clk);
        check_val("idle_sclk", spi_clk_a, m[1]);
        n0 = done_a;
        q_a.push_back(exp);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(n0 + 1, 1000);
        check_val("mosi_order", mosi_seen, lsb ? rev16(d) : d);
        check_val("mosi_stable", unstable_a, 0);
        check_val("sclk_rises", rises_a, 16);
        check_val("rest_sclk", spi_clk_a, m[1]);
    endtask

    initial begin
        int n0, lat;
        logic got;

        repeat (3) @(negedge clk);
        check_val("rst_pins", {spi_clk_a, spi_mosi_a, spi_cs_n_a, spi_str_a, busy_a, ready_a}, 6'b001000);
        check_val("rst_dout", dout_a, 16'h0000);
        check_val("rst_dout_b", dout_b, 8'h00);
        reset_n = 1'b1;

        // Loopback, mode 0, MSB first
        do_xfer(16'hA5C3, 2'b00, 1'b0, 1'b1, 16'hA5C3);

        // All four modes against the slave model
        for (int m = 0; m < 4; m++)
            do_xfer(16'h1234 ^ 16'(m * 16'h1111), 2'(m), 1'b0, 1'b0, 16'h3C5A);

        // LSB-first
        do_xfer(16'h0001, 2'b00, 1'b1, 1'b1, 16'h0001);
        do_xfer(16'hC01F, 2'b11, 1'b1, 1'b1, 16'hC01F);

        // Idle SCLK tracks live CPOL
        @(negedge clk); mode_a = 2'b10;
        @(negedge clk); check_val("idle_follow_1", spi_clk_a, 1'b1);
        mode_a = 2'b00;
        @(negedge clk); check_val("idle_follow_0", spi_clk_a, 1'b0);

        // Start and input changes during busy are ignored
        @(negedge clk);
        data_a = 16'h5AA5; mode_a = 2'b01; lsb_a = 1'b0; loop_a = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b1;
        @(negedge clk);
        n0 = done_a; q_a.push_back(16'h5AA5); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (100) @(negedge clk);
        start_a = 1'b1; data_a = 16'hFFFF; mode_a = 2'b10; lsb_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done_a(n0 + 1, 1000);
        check_val("busy_mosi_order", mosi_seen, 16'h5AA5);
        repeat (500) @(negedge clk);
        check_val("single_xfer", done_a - n0, 1);
        check_val("sb_drained", q_a.size(), 0);

        // Start held high: back-to-back words with one idle cycle between
        @(negedge clk);
        data_a = 16'h0F0F; mode_a = 2'b00; lsb_a = 1'b0; loop_a = 1'b1; cur_cpol = 1'b0; cur_cpha = 1'b0;
        @(negedge clk);
        n0 = done_a; q_a.push_back(16'h0F0F); q_a.push_back(16'h0F0F); start_a = 1'b1;
        @(negedge clk); b2b_chk = 1'b1;
        wait_done_a(n0 + 2, 2000);
        start_a = 1'b0;
        @(negedge clk); b2b_chk = 1'b0;
        check_val("b2b_count", done_a - n0, 2);

        // Reset mid-transfer, then a clean transfer
        @(negedge clk);
        data_a = 16'hBEEF; mode_a = 2'b10; lsb_a = 1'b0; loop_a = 1'b1; cur_cpol = 1'b1; cur_cpha = 1'b0;
        @(negedge clk);
        n0 = done_a; start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tog_a >= 10) break;
        end
        check_val("reach_tick10", tog_a >= 10, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_rst_pins", {spi_clk_a, spi_mosi_a, spi_cs_n_a, spi_str_a, busy_a, ready_a}, 6'b001000);
        check_val("mid_rst_dout", dout_a, 16'h0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (600) @(negedge clk);
        check_val("rst_no_ready", done_a - n0, 0);
        check_val("rst_dout_kept", dout_a, 16'h0000);
        do_xfer(16'h6B2D, 2'b11, 1'b0, 1'b1, 16'h6B2D);

        // 8-bit, DIV=1 instance
        @(negedge clk);
        data_b = 8'h96; q_b.push_back(8'h96); start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0; lat = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ready_b) begin
                got = 1'b1;
                break;
            end
        end
        check_val("b_ready_seen", got, 1'b1);
        check_val("b_latency", lat, 19);
        check_val("b_dout", dout_b, q_b.pop_front());
        check_val("b_edges", tog_b, 16);
        check_val("b_rest_sclk", spi_clk_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
